// File: rtl/ysyx_25030093_regfile_sb_if.sv
// Bundles the write-back, issue and read-port signals of the register file.
// The master side belongs to the decode/issue stage and the slave side to the register file.
interface ysyx_25030093_regfile_sb_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2
);
    logic                          wen;
    logic                          w_valid;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          issue_valid;
    logic [ADDR_WIDTH-1:0]         issue_addr;
    logic                          issue_ready;
    logic                          flush;
    logic [NREAD*ADDR_WIDTH-1:0]   rd_addr;
    logic [NREAD*DATA_WIDTH-1:0]   rd_data;
    logic [NREAD-1:0]              rd_busy;
    logic                          any_busy;

    modport master (
        output wen, w_valid, waddr, wdata, issue_valid, issue_addr, flush, rd_addr,
        input  issue_ready, rd_data, rd_busy, any_busy
    );

    modport slave (
        input  wen, w_valid, waddr, wdata, issue_valid, issue_addr, flush, rd_addr,
        output issue_ready, rd_data, rd_busy, any_busy
    );
endinterface

// File: rtl/ysyx_25030093_regfile_sb.sv
// Register file with combinational read ports, one write-back port and a
// per-register saturating pending-write scoreboard for RAW hazard detection.
module ysyx_25030093_regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned BYPASS     = 1
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_25030093_regfile_sb_if.slave bus
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] r_rf   [1:NREG-1];
    logic [CNT_WIDTH-1:0]  r_pend [1:NREG-1];

    logic                        w_wr_hit;
    logic                        w_iss_hit;
    logic                        w_issue_ready;
    logic [CNT_WIDTH-1:0]        w_iss_pend;
    logic [NREG-1:1]             w_inc;
    logic [NREG-1:1]             w_dec;
    logic [ADDR_WIDTH-1:0]       w_ra;
    logic [NREAD*DATA_WIDTH-1:0] w_rd_data;
    logic [NREAD-1:0]            w_rd_busy;
    logic                        w_any_busy;

    assign w_wr_hit = bus.wen & bus.w_valid & (bus.waddr != '0);

    always_comb begin
        w_iss_pend = '0;
        if (bus.issue_addr != '0) w_iss_pend = r_pend[bus.issue_addr];
    end

    // A full counter can still accept an issue when a write to it retires this cycle.
    assign w_issue_ready = (bus.issue_addr == '0) | (w_iss_pend != CNT_MAX) |
                           (w_wr_hit & (bus.waddr == bus.issue_addr));
    assign w_iss_hit     = bus.issue_valid & w_issue_ready & (bus.issue_addr != '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_iss_hit) w_inc[bus.issue_addr] = 1'b1;
        if (w_wr_hit)  w_dec[bus.waddr]      = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < NREG; r++) r_rf[r] <= '0;
        end else if (w_wr_hit) begin
            r_rf[bus.waddr] <= bus.wdata;
        end
    end

    // Writes with no pending count (in flight across a flush) leave the counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < NREG; r++) r_pend[r] <= '0;
        end else if (bus.flush) begin
            for (int unsigned r = 1; r < NREG; r++) r_pend[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_pend[r] <= r_pend[r] + CNT_WIDTH'(1);
                end else if (w_dec[r] && !w_inc[r] && (r_pend[r] != '0)) begin
                    r_pend[r] <= r_pend[r] - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_ra      = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            w_ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (w_ra != '0) begin
                if ((BYPASS != 0) && w_wr_hit && (bus.waddr == w_ra)) begin
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
                    w_rd_busy[i] = (r_pend[w_ra] > CNT_WIDTH'(1));
                end else begin
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_ra];
                    w_rd_busy[i] = (r_pend[w_ra] != '0);
                end
            end
        end
    end

    always_comb begin
        w_any_busy = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) w_any_busy = w_any_busy | (r_pend[r] != '0);
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.rd_data     = w_rd_data;
    assign bus.rd_busy     = w_rd_busy;
    assign bus.any_busy    = w_any_busy;
endmodule
